// File: rtl/ddram_access_pkg.sv
// Shared types and constants for the DDRAM access sequencer.
package ddram_access_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    WR_REQ   = 3'd2,
    RD_REQ   = 3'd3,
    RD_WAIT  = 3'd4,
    FILL     = 3'd5,
    FILL_END = 3'd6,
    DONE     = 3'd7
  } state_e;

  // Byte enables for the 32-bit half of the 64-bit DDRAM word.
  localparam logic [7:0] BE_LANE0 = 8'h0F;
  localparam logic [7:0] BE_LANE1 = 8'hF0;

  // Every transfer is a single 64-bit beat.
  localparam logic [7:0] DDR_BURSTCNT = 8'd1;

  // Lane byte enable from the low CPU address bit.
  function automatic logic [7:0] lane_be(input logic lane);
    return lane ? BE_LANE1 : BE_LANE0;
  endfunction

endpackage

// File: rtl/ddram_access_ctrl_lane_mux.sv
// Lane select and replication between a 32-bit CPU word and the 64-bit
// DDRAM word. Odd CPU word addresses live in the upper half.
module ddram_lane_mux
  import ddram_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    lane,
  input  logic [2*DATA_WIDTH-1:0] ddr_dout,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rd_word,
  output logic [2*DATA_WIDTH-1:0] ddr_din,
  output logic [7:0]              ddr_be
);

  assign rd_word = lane ? ddr_dout[2*DATA_WIDTH-1:DATA_WIDTH] : ddr_dout[DATA_WIDTH-1:0];
  // Write data is replicated to both halves; the byte enable picks the lane.
  assign ddr_din = {wdata, wdata};
  assign ddr_be  = lane_be(lane);

endmodule

// File: rtl/ddram_access_ctrl.sv
// Sequencer between the CPU memory port, a small side-lookup cache and the
// DDRAM Avalon-style master. Reads hit in the cache or fetch-and-fill;
// writes go through to DDRAM and update the cache line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request (blocked while a stray read is pending)
// LOOKUP   | cache_addr driven, waiting one cycle for cache_hit
// WR_REQ   | ddram_we held until accepted (busy low)
// RD_REQ   | ddram_rd held until accepted (busy low)
// RD_WAIT  | waiting for ddram_dout_ready
// FILL     | cache_wr high for one cycle
// FILL_END | cache_wr low; cache commits on this edge
// DONE     | cpu_ack pulse
module ddram_access_ctrl
  import ddram_access_pkg::*;
#(
  parameter int                        ADDR_WIDTH     = 8,
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        DDR_ADDR_WIDTH = 29,
  parameter logic [DDR_ADDR_WIDTH-1:0] DDR_BASE       = 29'h0300_0000,
  parameter int                        STAT_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_ack,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  output logic [ADDR_WIDTH-1:0]     cache_addr,
  output logic [DATA_WIDTH-1:0]     cache_wdata,
  output logic                      cache_wr,
  input  logic [DATA_WIDTH-1:0]     cache_rdata,
  input  logic                      cache_hit,
  input  logic                      ddram_busy,
  output logic [DDR_ADDR_WIDTH-1:0] ddram_addr,
  output logic [7:0]                ddram_burstcnt,
  output logic [63:0]               ddram_din,
  output logic [7:0]                ddram_be,
  output logic                      ddram_we,
  output logic                      ddram_rd,
  input  logic [63:0]               ddram_dout,
  input  logic                      ddram_dout_ready,
  output logic [STAT_WIDTH-1:0]     hit_count,
  output logic [STAT_WIDTH-1:0]     miss_count
);

  state_e                    state_q, state_d;
  logic                      req_we_q, req_we_d;
  logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;
  logic [ADDR_WIDTH-1:0]     cache_addr_q, cache_addr_d;
  logic [DATA_WIDTH-1:0]     cache_wdata_q, cache_wdata_d;
  logic [DATA_WIDTH-1:0]     cpu_rdata_q, cpu_rdata_d;
  logic [DDR_ADDR_WIDTH-1:0] ddram_addr_q, ddram_addr_d;
  logic [7:0]                ddram_be_q, ddram_be_d;
  logic [63:0]               ddram_din_q, ddram_din_d;
  logic [STAT_WIDTH-1:0]     hit_q, hit_d;
  logic [STAT_WIDTH-1:0]     miss_q, miss_d;
  logic                      rd_pending_q, rd_pending_d;

  logic [DATA_WIDTH-1:0]     lane_word;
  logic [63:0]               lane_din;
  logic [7:0]                lane_be_w;
  logic [DDR_ADDR_WIDTH-1:0] ddr_word_addr;

  // The captured CPU address doubles as the request address register.
  ddram_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_mux (
    .lane     (cache_addr_q[0]),
    .ddr_dout (ddram_dout),
    .wdata    (req_wdata_q),
    .rd_word  (lane_word),
    .ddr_din  (lane_din),
    .ddr_be   (lane_be_w)
  );

  // Two CPU words share one 64-bit DDRAM word.
  assign ddr_word_addr = DDR_BASE + DDR_ADDR_WIDTH'(cache_addr_q >> 1);

  // Next-state and datapath load decisions.
  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_wdata_d   = req_wdata_q;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = cache_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    ddram_addr_d  = ddram_addr_q;
    ddram_be_d    = ddram_be_q;
    ddram_din_d   = ddram_din_q;
    hit_d         = hit_q;
    miss_d        = miss_q;

    unique case (state_q)
      IDLE: begin
        if (cpu_req && !rd_pending_q) begin
          req_we_d     = cpu_we;
          req_wdata_d  = cpu_wdata;
          cache_addr_d = cpu_addr;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        if (req_we_q) begin
          // Write-through regardless of hit: DDRAM first, then the cache line.
          ddram_addr_d = ddr_word_addr;
          ddram_be_d   = lane_be_w;
          ddram_din_d  = lane_din;
          state_d      = WR_REQ;
        end else if (cache_hit) begin
          cpu_rdata_d = cache_rdata;
          if (hit_q != '1) hit_d = hit_q + STAT_WIDTH'(1);
          state_d = DONE;
        end else begin
          if (miss_q != '1) miss_d = miss_q + STAT_WIDTH'(1);
          ddram_addr_d = ddr_word_addr;
          ddram_be_d   = lane_be_w;
          state_d      = RD_REQ;
        end
      end
      WR_REQ: begin
        if (!ddram_busy) begin
          cache_wdata_d = req_wdata_q;
          state_d       = FILL;
        end
      end
      RD_REQ: begin
        if (!ddram_busy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (ddram_dout_ready) begin
          cpu_rdata_d   = lane_word;
          cache_wdata_d = lane_word;
          state_d       = FILL;
        end
      end
      FILL:     state_d = FILL_END;
      FILL_END: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Controller state and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      req_we_q      <= 1'b0;
      req_wdata_q   <= '0;
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      cpu_rdata_q   <= '0;
      ddram_addr_q  <= DDR_BASE;
      ddram_be_q    <= '0;
      ddram_din_q   <= '0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_wdata_q   <= req_wdata_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      ddram_addr_q  <= ddram_addr_d;
      ddram_be_q    <= ddram_be_d;
      ddram_din_q   <= ddram_din_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  // Outstanding-read tracker. Set whenever the read strobe is accepted,
  // even on a reset edge, since DDRAM will still return the data; cleared
  // only when that data arrives so a reset cannot orphan it.
  always_comb begin
    rd_pending_d = rd_pending_q;
    if (rd_pending_q && ddram_dout_ready) begin
      rd_pending_d = 1'b0;
    end else if (state_q == RD_REQ && !ddram_busy) begin
      rd_pending_d = 1'b1;
    end
  end

  // Deliberately outside reset: survives reset to drain a stray read.
  always_ff @(posedge clk) begin
    rd_pending_q <= rd_pending_d;
  end

  assign cpu_ready      = (state_q == IDLE) && !rd_pending_q;
  assign cpu_ack        = (state_q == DONE);
  assign cpu_rdata      = cpu_rdata_q;
  assign cache_addr     = cache_addr_q;
  assign cache_wdata    = cache_wdata_q;
  assign cache_wr       = (state_q == FILL);
  assign ddram_we       = (state_q == WR_REQ);
  assign ddram_rd       = (state_q == RD_REQ);
  assign ddram_addr     = ddram_addr_q;
  assign ddram_be       = ddram_be_q;
  assign ddram_din      = ddram_din_q;
  assign ddram_burstcnt = DDR_BURSTCNT;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule

// File: tb/tb_ddram_access_ctrl.sv
// Scoreboard bench for ddram_access_ctrl: stimulus pushes expected acks,
// DDRAM strobes and cache fills; a negedge monitor pops and compares.
module tb_ddram_access_ctrl;

  localparam logic [28:0] BASE = 29'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready, cpu_ack;
  logic [31:0] cpu_rdata;
  logic [7:0]  cache_addr;
  logic [31:0] cache_wdata;
  logic        cache_wr;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        ddram_busy;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_we, ddram_rd;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic [15:0] hit_count, miss_count;

  // small-counter instance for saturation
  logic        s_req;
  logic [7:0]  s_addr;
  logic        s_ready, s_ack, s_cache_wr, s_we_o, s_rd_o;
  logic [31:0] s_rdata, s_cache_wdata;
  logic [7:0]  s_cache_addr, s_burst, s_be;
  logic [28:0] s_ddr_addr;
  logic [63:0] s_din;
  logic [1:0]  s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  ddram_access_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_wr(cache_wr),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .ddram_busy(ddram_busy), .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_we(ddram_we), .ddram_rd(ddram_rd),
    .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  ddram_access_ctrl #(.STAT_WIDTH(2)) sat_dut (
    .clk(clk), .reset(reset),
    .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(s_addr), .cpu_wdata(32'h0),
    .cpu_ready(s_ready), .cpu_ack(s_ack), .cpu_rdata(s_rdata),
    .cache_addr(s_cache_addr), .cache_wdata(s_cache_wdata), .cache_wr(s_cache_wr),
    .cache_rdata(32'h0BADF00D), .cache_hit(1'b1),
    .ddram_busy(1'b0), .ddram_addr(s_ddr_addr), .ddram_burstcnt(s_burst),
    .ddram_din(s_din), .ddram_be(s_be), .ddram_we(s_we_o), .ddram_rd(s_rd_o),
    .ddram_dout(64'h0), .ddram_dout_ready(1'b0),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  typedef struct {bit chk; logic [31:0] data; int cyc;} ack_t;
  typedef struct {bit we; logic [28:0] addr; logic [7:0] be; logic [63:0] din;} ddr_t;
  typedef struct {logic [7:0] addr; logic [31:0] data;} fill_t;

  ack_t  ack_q[$];
  ddr_t  ddr_q[$];
  fill_t fill_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int we_cycles = 0;

  // responder controls, written only by the stimulus process
  bit          auto_rsp = 1'b1;
  int          busy_cfg = 0;
  logic [63:0] rsp_data = 64'h0;
  int          stray_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DDRAM slave model: busy for busy_cfg cycles per strobe, read data the
  // cycle after acceptance; in manual mode only the stray beat is produced.
  initial begin : responder
    int  budget;
    bit  prev_strobe;
    bit  rd_fire;
    int  stray_done;
    budget = 0; prev_strobe = 0; rd_fire = 0; stray_done = 0;
    ddram_busy = 0; ddram_dout_ready = 0; ddram_dout = 64'h0;
    forever begin
      @(posedge clk); #1;
      if (auto_rsp) begin
        ddram_dout_ready = rd_fire;
        if (rd_fire) ddram_dout = rsp_data;
        rd_fire = 0;
        if ((ddram_we || ddram_rd) && !prev_strobe) budget = busy_cfg;
        if ((ddram_we || ddram_rd) && budget > 0) begin
          ddram_busy = 1; budget--;
        end else begin
          ddram_busy = 0;
        end
        if (ddram_rd && !ddram_busy) rd_fire = 1;
        prev_strobe = ddram_we || ddram_rd;
      end else begin
        ddram_busy = 0;
        if (stray_req != stray_done) begin
          ddram_dout_ready = 1; ddram_dout = 64'hFEEDFACE_C0FFEE00; stray_done++;
        end else begin
          ddram_dout_ready = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the expectation queues.
  initial begin : monitor
    bit   prev_cache_wr;
    ack_t a;
    ddr_t d;
    fill_t f;
    prev_cache_wr = 0;
    forever begin
      @(negedge clk);
      if (cpu_ack) begin
        if (ack_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack want none (cycle %0d)", cyc);
        end else begin
          a = ack_q.pop_front();
          check("ack_cycle", 64'(cyc), 64'(a.cyc));
          if (a.chk) check("ack_rdata", {32'h0, cpu_rdata}, {32'h0, a.data});
        end
      end
      if (ddram_we && ddram_rd) begin
        total++; bad++;
        $display("FAIL strobes_overlap: got we=1 rd=1 want exclusive (cycle %0d)", cyc);
      end
      if (ddram_we) we_cycles++;
      if (ddram_we || ddram_rd) begin
        if (ddr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got we=%0b rd=%0b want none", ddram_we, ddram_rd);
        end else begin
          d = ddr_q[0];
          check("ddr_is_write", 64'(ddram_we), 64'(d.we));
          check("ddr_addr", 64'(ddram_addr), 64'(d.addr));
          check("ddr_burstcnt", 64'(ddram_burstcnt), 64'd1);
          if (d.we) begin
            check("ddr_be", 64'(ddram_be), 64'(d.be));
            check("ddr_din", ddram_din, d.din);
          end
          if (!ddram_busy) d = ddr_q.pop_front();
        end
      end
      if (cache_wr) begin
        if (prev_cache_wr) begin
          total++; bad++;
          $display("FAIL cache_wr_width: got 2+ cycles want 1 (cycle %0d)", cyc);
        end
        if (fill_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fill: got cache_wr addr %0h want none", cache_addr);
        end else begin
          f = fill_q.pop_front();
          check("fill_addr", 64'(cache_addr), 64'(f.addr));
          check("fill_data", 64'(cache_wdata), 64'(f.data));
        end
      end
      prev_cache_wr = cache_wr;
    end
  end

  task automatic issue(input bit we, input logic [7:0] a, input logic [31:0] d, output int c);
    int n = 0;
    while (!cpu_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!cpu_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: got cpu_ready=0 want 1");
    end
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; c = cyc;
    @(posedge clk); #1;
    cpu_req = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((ack_q.size() != 0 || !cpu_ready) && n < 100) begin @(posedge clk); #1; n++; end
    if (ack_q.size() != 0 || !cpu_ready) begin
      total++; bad++;
      $display("FAIL done_timeout: got pending=%0d ready=%0b want 0/1", ack_q.size(), cpu_ready);
    end
  endtask

  initial begin : stim
    int c, n, w0;
    bit got;
    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cache_hit = 0; cache_rdata = 0; s_req = 0; s_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(cpu_ready), 64'd1);
    check("rst_ack", 64'(cpu_ack), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_cache_wr", 64'(cache_wr), 64'd0);
    check("rst_cache_addr", 64'(cache_addr), 64'd0);
    check("rst_cache_wdata", 64'(cache_wdata), 64'd0);
    check("rst_strobes", {62'h0, ddram_we, ddram_rd}, 64'd0);
    check("rst_ddr_addr", 64'(ddram_addr), 64'(BASE));
    check("rst_ddr_be", 64'(ddram_be), 64'd0);
    check("rst_ddr_din", ddram_din, 64'd0);
    check("rst_counts", {32'h0, hit_count, miss_count}, 64'd0);
    @(posedge clk); #1;
    reset = 0;

    // read miss, odd address -> upper lane
    cache_hit = 0; rsp_data = 64'hAAAA5555_12345678; busy_cfg = 0;
    ddr_q.push_back('{1'b0, BASE + 29'd2, 8'h00, 64'h0});
    fill_q.push_back('{8'h05, 32'hAAAA5555});
    issue(0, 8'h05, 32'h0, c);
    ack_q.push_back('{1'b1, 32'hAAAA5555, c + 6});
    wait_done();
    check("miss_count_1", 64'(miss_count), 64'd1);

    // read miss, even address -> lower lane, DDRAM busy 2 cycles
    rsp_data = 64'h11112222_33334444; busy_cfg = 2;
    ddr_q.push_back('{1'b0, BASE + 29'd5, 8'h00, 64'h0});
    fill_q.push_back('{8'h0A, 32'h33334444});
    issue(0, 8'h0A, 32'h0, c);
    ack_q.push_back('{1'b1, 32'h33334444, c + 8});
    wait_done();
    check("miss_count_2", 64'(miss_count), 64'd2);

    // read hit
    cache_hit = 1; cache_rdata = 32'hDEADBEEF;
    issue(0, 8'h10, 32'h0, c);
    ack_q.push_back('{1'b0, 32'h0, c + 2});
    ack_q[0].chk = 1; ack_q[0].data = 32'hDEADBEEF;
    wait_done();
    check("hit_count_1", 64'(hit_count), 64'd1);

    // write, lane 0, busy 3 cycles -> we held 4
    cache_hit = 0; busy_cfg = 3; w0 = we_cycles;
    ddr_q.push_back('{1'b1, BASE + 29'd2, 8'h0F, 64'h01020304_01020304});
    fill_q.push_back('{8'h04, 32'h01020304});
    issue(1, 8'h04, 32'h01020304, c);
    ack_q.push_back('{1'b0, 32'h0, c + 8});
    wait_done();
    check("we_hold_cycles", 64'(we_cycles - w0), 64'd4);

    // write, lane 1, cache reporting hit, no busy
    cache_hit = 1; busy_cfg = 0;
    ddr_q.push_back('{1'b1, BASE + 29'd3, 8'hF0, 64'hCAFEF00D_CAFEF00D});
    fill_q.push_back('{8'h07, 32'hCAFEF00D});
    issue(1, 8'h07, 32'hCAFEF00D, c);
    ack_q.push_back('{1'b0, 32'h0, c + 5});
    wait_done();
    check("rdata_held", 64'(cpu_rdata), 64'hDEADBEEF);
    check("counts_after_wr", {32'h0, hit_count, miss_count}, {32'h0, 16'd1, 16'd2});

    // second pulse during LOOKUP is ignored; next one after ready is taken
    cache_rdata = 32'h55AA55AA;
    issue(0, 8'h20, 32'h0, c);
    ack_q.push_back('{1'b1, 32'h55AA55AA, c + 2});
    cpu_req = 1; cpu_addr = 8'h21;
    @(negedge clk);
    check("b2b_ready_low", 64'(cpu_ready), 64'd0);
    @(posedge clk); #1;
    cpu_req = 0;
    wait_done();
    cache_rdata = 32'h13579BDF;
    issue(0, 8'h22, 32'h0, c);
    ack_q.push_back('{1'b1, 32'h13579BDF, c + 2});
    wait_done();
    check("hit_count_3", 64'(hit_count), 64'd3);

    // reset while in RD_WAIT: stray data drained, no fill, no ack
    auto_rsp = 0; cache_hit = 0;
    ddr_q.push_back('{1'b0, BASE + 29'd1, 8'h00, 64'h0});
    issue(0, 8'h03, 32'h0, c);
    n = 0;
    while (!ddram_rd && n < 20) begin @(posedge clk); #1; n++; end
    check("stray_rd_seen", 64'(ddram_rd), 64'd1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_ready_held", 64'(cpu_ready), 64'd0);
    end
    check("rst_counts_2", {32'h0, hit_count, miss_count}, 64'd0);
    check("rst_ddr_addr_2", 64'(ddram_addr), 64'(BASE));
    @(posedge clk); #1;
    stray_req++;
    got = 0; n = 0;
    while (!got && n < 10) begin @(negedge clk); if (ddram_dout_ready) got = 1; n++; end
    check("stray_data_seen", 64'(got), 64'd1);
    check("stray_ready_low", 64'(cpu_ready), 64'd0);
    @(negedge clk);
    check("stray_ready_rise", 64'(cpu_ready), 64'd1);
    @(posedge clk); #1;
    auto_rsp = 1;

    // recovery: read hit after the drain
    cache_hit = 1; cache_rdata = 32'h0F0F1234;
    issue(0, 8'h33, 32'h0, c);
    ack_q.push_back('{1'b1, 32'h0F0F1234, c + 2});
    wait_done();
    check("post_rst_counts", {32'h0, hit_count, miss_count}, {32'h0, 16'd1, 16'd0});

    // saturation on the 2-bit counter instance: 5 hits -> 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      n = 0;
      while (!s_ready && n < 20) begin @(posedge clk); #1; n++; end
      s_req = 1; s_addr = 8'(k);
      @(posedge clk); #1;
      s_req = 0;
      got = 0; n = 0;
      while (!got && n < 20) begin @(negedge clk); if (s_ack) got = 1; n++; end
      check("sat_ack_seen", 64'(got), 64'd1);
      check("sat_hit_count", 64'(s_hit_count), (k > 3) ? 64'd3 : 64'(k));
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("ack_q_empty", 64'(ack_q.size()), 64'd0);
    check("ddr_q_empty", 64'(ddr_q.size()), 64'd0);
    check("fill_q_empty", 64'(fill_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
